sub_serial: RTL and testbench

//  - Multi-cycle subtractor for the ALU datapath; inverse operation of the combinational adder.
//  - Computes respuesta = A - B as A + ~B + 1, DIGIT bits per clock, LSB digit first.
//  - Produces Z/N/C/V flags with the same meaning as the adder flags; C = NOT borrow.
//  - Start/done handshake toward the ALU control sequencer; operands latched at start.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/sub_digit.sv | 15 +
 rtl/sub_serial.sv | 143 ++++++++++++++
 tb/tb_sub_serial.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: subtractor FSM states, the Z/N/C/V flag bundle and the
// flag-derivation helper used when a serial subtraction completes.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    // Flags of A - B; N and V only carry meaning under signed rules.
    function automatic alu_flags_t sub_flags(
        input logic res_zero,
        input logic res_msb,
        input logic cout,
        input logic a_msb,
        input logic b_msb,
        input logic sgn
    );
        alu_flags_t f;
        f.z = res_zero;
        f.n = sgn & res_msb;
        f.c = cout;
        f.v = sgn & (a_msb ^ b_msb) & (res_msb ^ a_msb);
        return f;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// One DIGIT-wide slice of A + ~B + 1; the caller supplies the already
// inverted subtrahend digit and the running carry.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b_inverted,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b_inverted} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/sub_serial.sv
// Digit-serial subtractor A - B with start/done handshake and Z/N/C/V flags.
// Optional feature: define SUB_SERIAL_LT_EN to add the registered 'lt' output.
module sub_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] respuesta,
    output logic             Z,
    output logic             N,
    output logic             C,
`ifdef SUB_SERIAL_LT_EN
    output logic             V,
    output logic             lt
`else
    output logic             V
`endif
);

    localparam int N_DIG = WIDTH / DIGIT;
    localparam int CW    = $clog2(N_DIG);
    localparam logic [CW-1:0] LAST = CW'(N_DIG - 1);

    sub_state_t             r_state;
    sub_state_t             w_next;
    logic                   w_accept;
    logic [CW-1:0]          r_count;
    logic                   r_carry;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_sign;
    // Holds every digit but the last; the final digit joins it on commit.
    logic [WIDTH-DIGIT-1:0] r_part;
    logic                   r_busy;
    logic                   r_done;
    logic [WIDTH-1:0]       r_res;
    alu_flags_t             r_flags;
    alu_flags_t             w_flags;
    logic [DIGIT-1:0]       w_sum;
    logic                   w_cout;
    logic [WIDTH-1:0]       w_res;

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a          (r_a[int'(r_count) * DIGIT +: DIGIT]),
        .b_inverted (~r_b[int'(r_count) * DIGIT +: DIGIT]),
        .cin        (r_carry),
        .sum        (w_sum),
        .cout       (w_cout)
    );

    assign w_res   = {w_sum, r_part};
    assign w_flags = sub_flags(w_res == {WIDTH{1'b0}}, w_res[WIDTH-1], w_cout,
                               r_a[WIDTH-1], r_b[WIDTH-1], r_sign);

    // Next-state decode and operand-accept strobe.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end else begin
                    w_next   = IDLE;
                end
            end
            RUN: begin
                if (r_count == LAST) begin
                    w_next = DONE;
                end else begin
                    w_next = RUN;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == RUN);
            r_done  <= (w_next == DONE);
        end
    end

    // Operand latch, digit iteration and result/flag commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CW{1'b0}};
            r_carry <= 1'b0;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_sign  <= 1'b0;
            r_part  <= {(WIDTH-DIGIT){1'b0}};
            r_res   <= {WIDTH{1'b0}};
            r_flags <= '0;
`ifdef SUB_SERIAL_LT_EN
            lt      <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_sign  <= sign;
            r_count <= {CW{1'b0}};
            r_carry <= 1'b1;
        end else if (r_state == RUN) begin
            r_part  <= {w_sum, r_part[WIDTH-DIGIT-1:DIGIT]};
            r_carry <= w_cout;
            r_count <= r_count + CW'(1);
            if (r_count == LAST) begin
                r_res   <= w_res;
                r_flags <= w_flags;
`ifdef SUB_SERIAL_LT_EN
                lt      <= r_sign ? (w_flags.n ^ w_flags.v) : ~w_flags.c;
`endif
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign respuesta = r_res;
    assign Z         = r_flags.z;
    assign N         = r_flags.n;
    assign C         = r_flags.c;
    assign V         = r_flags.v;

endmodule

// File: tb/tb_sub_serial.sv
// Randomized self-checking bench for sub_serial against an arithmetic model.
module tb_sub_serial;

    localparam int W  = 32;
    localparam int ND = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sgn;
    logic          busy;
    logic          done;
    logic [W-1:0]  res;
    logic          z, n, c, v;
`ifdef SUB_SERIAL_LT_EN
    logic          lt;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic [W-1:0]  prev_res = '0;

    sub_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (a),
        .B         (b),
        .sign      (sgn),
        .busy      (busy),
        .done      (done),
        .respuesta (res),
        .Z         (z),
        .N         (n),
        .C         (c),
`ifdef SUB_SERIAL_LT_EN
        .V         (v),
        .lt        (lt)
`else
        .V         (v)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain two's-complement arithmetic and comparisons.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] r, output logic ez, output logic en,
                         output logic ec, output logic ev, output logic elt);
        r   = ma - mb;
        ez  = (r == '0);
        ec  = (ma >= mb);
        en  = ms & r[W-1];
        ev  = ms & ((ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]));
        elt = ms ? ($signed(ma) < $signed(mb)) : (ma < mb);
    endtask

    task automatic check_result(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
        logic [W-1:0] r;
        logic ez, en, ec, ev, elt;
        model(ma, mb, ms, r, ez, en, ec, ev, elt);
        check("respuesta", 64'(res), 64'(r));
        check("Z", 64'(z), 64'(ez));
        check("N", 64'(n), 64'(en));
        check("C", 64'(c), 64'(ec));
        check("V", 64'(v), 64'(ev));
`ifdef SUB_SERIAL_LT_EN
        check("lt", 64'(lt), 64'(elt));
`endif
        prev_res = r;
    endtask

    // Waits (bounded) for done; lat is edges since cycle c0, 0 on timeout.
    task automatic wait_done(input int c0, input bit chk_hold, output int lat);
        lat = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = cyc - c0;
                break;
            end
            if (chk_hold) check("held_result", 64'(res), 64'(prev_res));
        end
    endtask

    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          output int c0);
        @(negedge clk);
        start = 1'b1;
        a = ta;
        b = tb;
        sgn = ts;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
        check("busy_run", 64'(busy), 64'd1);
        a = $urandom;
        b = $urandom;
        sgn = ~ts;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        int c0, lat;
        launch(ta, tb, ts, c0);
        wait_done(c0, 1'b1, lat);
        check("latency", 64'(lat), 64'(ND));
        check("busy_done", 64'(busy), 64'd0);
        check_result(ta, tb, ts);
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done), 64'd0);
        check("held_after", 64'(res), 64'(prev_res));
    endtask

    initial begin
        int c0, lat;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        sgn = 1'b0;
        #23;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        check("rst_flags", 64'({z, n, c, v}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd5, 32'd3, 1'b1);
        run_op(32'd3, 32'd5, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b1);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1);
        run_op(32'd0, 32'd0, 1'b0);
        run_op(32'hDEAD_BEEF, 32'd0, 1'b1);

        // Back-to-back: start held through DONE launches the next op.
        @(negedge clk);
        start = 1'b1;
        a = 32'h0000_1000;
        b = 32'h0000_2000;
        sgn = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        wait_done(c0, 1'b0, lat);
        check("b2b_first_lat", 64'(lat), 64'(ND));
        check_result(32'h0000_1000, 32'h0000_2000, 1'b1);
        a = 32'h7FFF_FFFF;
        b = 32'hFFFF_FFFF;
        sgn = 1'b1;
        c0 = cyc;
        wait_done(c0, 1'b0, lat);
        check("b2b_gap", 64'(lat), 64'(ND + 1));
        check_result(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_done_drop", 64'(done), 64'd0);

        // start pulsed mid-RUN must be ignored.
        launch(32'd100, 32'd42, 1'b0, c0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c0, 1'b1, lat);
        check("midrun_lat", 64'(lat), 64'(ND));
        check_result(32'd100, 32'd42, 1'b0);
        lat = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) lat++;
        end
        check("midrun_extra_done", 64'(lat), 64'd0);

        // Asynchronous reset in the middle of RUN.
        launch(32'h0F0F_0F0F, 32'h0000_0001, 1'b1, c0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_res", 64'(res), 64'd0);
        check("arst_flags", 64'({z, n, c, v}), 64'd0);
        prev_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) lat++;
        end
        check("arst_no_done", 64'(lat), 64'd0);
        run_op(32'h0000_0007, 32'h0000_0009, 1'b1);

        // Randomized operands with boundary-biased cases.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: rb = '0;
                2: ra = '0;
                3: begin
                    ra[W-1] = ~rb[W-1];
                end
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
